// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream packet source. On a start pulse it emits
// pkt_count packets of pkt_len bytes with an incrementing byte pattern,
// partial last-beat keep, SOF on tuser and a programmable inter-packet gap.
module axis_pkt_gen #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1,
    parameter int LEN_W  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic [15:0]           pkt_count,
    input  logic [7:0]            gap,
    input  logic [7:0]            seed,
    input  logic [ID_W-1:0]       cfg_id,
    input  logic [DEST_W-1:0]     cfg_dest,
    output logic                  busy,
    output logic                  done,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tstrb,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [ID_W-1:0]       m_axis_tid,
    output logic [DEST_W-1:0]     m_axis_tdest,
    output logic                  m_axis_tuser
);

    localparam int B = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    // Keep mask of the last beat: low (len mod B) lanes, or all lanes when it divides evenly.
    function automatic logic [B-1:0] calc_last_keep(input logic [LEN_W-1:0] len);
        logic [B-1:0] k;
        int           rem;
        rem = int'(len % LEN_W'(B));
        for (int j = 0; j < B; j++) begin
            k[j] = (rem == 0) || (j < rem);
        end
        return k;
    endfunction

    // Beat payload: lane j carries base+j, lanes with keep low are zeroed.
    function automatic logic [DATA_W-1:0] beat_data(input logic [7:0] base, input logic [B-1:0] keep);
        logic [DATA_W-1:0] d;
        for (int j = 0; j < B; j++) begin
            d[8*j +: 8] = keep[j] ? (base + 8'(j)) : 8'h00;
        end
        return d;
    endfunction

    state_t            state_q;
    // Beat index within a packet; (2^LEN_W-1)/B always fits in LEN_W bits.
    logic [LEN_W-1:0]  beat_q;
    logic [LEN_W-1:0]  last_idx_q;
    logic [B-1:0]      last_keep_q;
    logic [15:0]       count_q;
    logic [15:0]       pkt_q;
    logic [7:0]        gap_q;
    logic [7:0]        gap_cnt_q;
    logic [7:0]        pkt_base_q;
    logic [7:0]        base_q;
    logic [ID_W-1:0]   id_q;
    logic [DEST_W-1:0] dest_q;
    logic              busy_q;
    logic              done_q;
    logic              tvalid_q;
    logic [DATA_W-1:0] tdata_q;
    logic [B-1:0]      tkeep_q;
    logic              tlast_q;
    logic              tuser_q;

    logic [LEN_W-1:0]  len_eff_d;
    logic [LEN_W-1:0]  cfg_last_idx_d;
    logic [B-1:0]      cfg_last_keep_d;
    logic [B-1:0]      first_keep_d;
    logic [DATA_W-1:0] first_data_d;
    logic [LEN_W-1:0]  in_idx_d;
    logic [7:0]        in_base_d;
    logic [B-1:0]      in_keep_d;
    logic [DATA_W-1:0] in_data_d;
    logic [7:0]        np_base_d;
    logic [B-1:0]      np_keep_d;
    logic [DATA_W-1:0] np_data_d;

    // Candidate payloads: first beat of a run, next beat in packet, first beat of next packet.
    always_comb begin
        len_eff_d       = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
        cfg_last_idx_d  = (len_eff_d - LEN_W'(1)) / LEN_W'(B);
        cfg_last_keep_d = calc_last_keep(len_eff_d);
        first_keep_d    = (cfg_last_idx_d == '0) ? cfg_last_keep_d : {B{1'b1}};
        first_data_d    = beat_data(seed, first_keep_d);
        in_idx_d        = beat_q + LEN_W'(1);
        in_base_d       = base_q + 8'(B);
        in_keep_d       = (in_idx_d == last_idx_q) ? last_keep_q : {B{1'b1}};
        in_data_d       = beat_data(in_base_d, in_keep_d);
        np_base_d       = pkt_base_q + 8'd1;
        np_keep_d       = (last_idx_q == '0) ? last_keep_q : {B{1'b1}};
        np_data_d       = beat_data(np_base_d, np_keep_d);
    end

    // Control FSM with registered stream and status outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            last_idx_q  <= '0;
            last_keep_q <= '0;
            count_q     <= 16'd0;
            pkt_q       <= 16'd0;
            gap_q       <= 8'd0;
            gap_cnt_q   <= 8'd0;
            pkt_base_q  <= 8'd0;
            base_q      <= 8'd0;
            id_q        <= '0;
            dest_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q   <= 1'b0;
                    tvalid_q <= 1'b0;
                    if (start) begin
                        last_idx_q  <= cfg_last_idx_d;
                        last_keep_q <= cfg_last_keep_d;
                        count_q     <= pkt_count;
                        gap_q       <= gap;
                        id_q        <= cfg_id;
                        dest_q      <= cfg_dest;
                        if (pkt_count == 16'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_SEND;
                            busy_q     <= 1'b1;
                            tvalid_q   <= 1'b1;
                            tdata_q    <= first_data_d;
                            tkeep_q    <= first_keep_d;
                            tlast_q    <= (cfg_last_idx_d == '0);
                            tuser_q    <= 1'b1;
                            beat_q     <= '0;
                            base_q     <= seed;
                            pkt_q      <= 16'd0;
                            pkt_base_q <= seed;
                        end
                    end
                end
                S_SEND: begin
                    if (tvalid_q && m_axis_tready) begin
                        if (!tlast_q) begin
                            beat_q  <= in_idx_d;
                            base_q  <= in_base_d;
                            tdata_q <= in_data_d;
                            tkeep_q <= in_keep_d;
                            tlast_q <= (in_idx_d == last_idx_q);
                            tuser_q <= 1'b0;
                        end else if (pkt_q == count_q - 16'd1) begin
                            state_q  <= S_DONE;
                            tvalid_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else if (gap_q == 8'd0) begin
                            pkt_q      <= pkt_q + 16'd1;
                            pkt_base_q <= np_base_d;
                            base_q     <= np_base_d;
                            beat_q     <= '0;
                            tdata_q    <= np_data_d;
                            tkeep_q    <= np_keep_d;
                            tlast_q    <= (last_idx_q == '0);
                            tuser_q    <= 1'b1;
                        end else begin
                            state_q   <= S_GAP;
                            tvalid_q  <= 1'b0;
                            gap_cnt_q <= gap_q;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == 8'd1) begin
                        state_q    <= S_SEND;
                        tvalid_q   <= 1'b1;
                        pkt_q      <= pkt_q + 16'd1;
                        pkt_base_q <= np_base_d;
                        base_q     <= np_base_d;
                        beat_q     <= '0;
                        tdata_q    <= np_data_d;
                        tkeep_q    <= np_keep_d;
                        tlast_q    <= (last_idx_q == '0);
                        tuser_q    <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tstrb  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tid    = id_q;
    assign m_axis_tdest  = dest_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: directed and randomized runs checked
// against a byte-stream reference model.
module tb_axis_pkt_gen;

    localparam int DW  = 32;
    localparam int IDW = 2;
    localparam int DSW = 3;
    localparam int LW  = 16;
    localparam int B   = DW / 8;

    logic            aclk = 1'b0;
    logic            areset;
    logic            start;
    logic [LW-1:0]   pkt_len;
    logic [15:0]     pkt_count;
    logic [7:0]      gap;
    logic [7:0]      seed;
    logic [IDW-1:0]  cfg_id;
    logic [DSW-1:0]  cfg_dest;
    logic            busy;
    logic            done;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [B-1:0]    m_axis_tstrb;
    logic [B-1:0]    m_axis_tkeep;
    logic            m_axis_tlast;
    logic [IDW-1:0]  m_axis_tid;
    logic [DSW-1:0]  m_axis_tdest;
    logic            m_axis_tuser;

    axis_pkt_gen #(.DATA_W(DW), .ID_W(IDW), .DEST_W(DSW), .LEN_W(LW)) dut (
        .aclk(aclk), .areset(areset), .start(start), .pkt_len(pkt_len),
        .pkt_count(pkt_count), .gap(gap), .seed(seed), .cfg_id(cfg_id),
        .cfg_dest(cfg_dest), .busy(busy), .done(done),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
        .m_axis_tuser(m_axis_tuser)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [B-1:0]  keep;
        logic          last;
        logic          user;
    } beat_t;

    beat_t exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: packet p is the byte string seed+p, seed+p+1, ... of length L,
    // cut into B-byte beats; bytes past L are absent (keep 0, data 0).
    function automatic void build_model(input int len, input int cnt, input logic [7:0] sd);
        int    l;
        int    nb;
        beat_t b;
        exp_q.delete();
        l  = (len == 0) ? 1 : len;
        nb = (l + B - 1) / B;
        for (int p = 0; p < cnt; p++) begin
            for (int i = 0; i < nb; i++) begin
                b.data = '0;
                b.keep = '0;
                for (int j = 0; j < B; j++) begin
                    if (i * B + j < l) begin
                        b.keep[j]        = 1'b1;
                        b.data[8*j +: 8] = 8'(int'(sd) + p + i * B + j);
                    end
                end
                b.last = (i == nb - 1);
                b.user = (i == 0);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [63:0] payload();
        return 64'({m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast,
                    m_axis_tuser, m_axis_tid, m_axis_tdest});
    endfunction

    // mode 0: tready high; 1: random; 2: low for 110 time units then random.
    task automatic run_test(input int len, input int cnt, input int gp, input logic [7:0] sd,
                            input int mode, input bit inject, input bit has_first,
                            input logic [DW-1:0] first_data);
        logic [IDW-1:0] eid;
        logic [DSW-1:0] edst;
        logic [63:0]    prev_pl;
        bit             prev_stall, gap_mode, expect_done, finished;
        int             idle, cycles;
        longint         t0;
        beat_t          eb;
        eid  = IDW'($urandom);
        edst = DSW'($urandom);
        build_model(len, cnt, sd);
        pkt_len = LW'(len); pkt_count = 16'(cnt); gap = 8'(gp); seed = sd;
        cfg_id = eid; cfg_dest = edst;
        m_axis_tready = (mode == 0);
        start = 1'b1;
        t0 = $time;
        step();
        start = 1'b0;
        if (cnt == 0) begin
            check_eq("zero_done", 64'(done), 64'd1);
            check_eq("zero_busy", 64'(busy), 64'd0);
            check_eq("zero_tvalid", 64'(m_axis_tvalid), 64'd0);
            step();
            check_eq("zero_done_pulse", 64'(done), 64'd0);
            check_eq("zero_busy2", 64'(busy), 64'd0);
            return;
        end
        check_eq("start_busy", 64'(busy), 64'd1);
        check_eq("start_tvalid", 64'(m_axis_tvalid), 64'd1);
        if (has_first) check_eq("first_beat", 64'(m_axis_tdata), 64'(first_data));
        prev_stall = 1'b0; gap_mode = 1'b0; expect_done = 1'b0; finished = 1'b0;
        idle = 0; cycles = 0; prev_pl = '0;
        while (!finished && cycles < 5000) begin
            if (expect_done) begin
                start = 1'b0;
                check_eq("done_after_last", 64'(done), 64'd1);
                check_eq("busy_at_done", 64'(busy), 64'd0);
                check_eq("tvalid_at_done", 64'(m_axis_tvalid), 64'd0);
                step();
                check_eq("done_pulse", 64'(done), 64'd0);
                check_eq("busy_after", 64'(busy), 64'd0);
                finished = 1'b1;
            end else begin
                check_eq("early_done", 64'(done), 64'd0);
                if (m_axis_tvalid) begin
                    check_eq("busy_in_run", 64'(busy), 64'd1);
                    if (prev_stall) check_eq("stable", payload(), prev_pl);
                    if (gap_mode) begin
                        check_eq("gap_len", 64'(idle), 64'(gp));
                        gap_mode = 1'b0;
                    end
                end else if (gap_mode) begin
                    idle++;
                end else begin
                    check_eq("bubble", 64'(m_axis_tvalid), 64'd1);
                end
                if (mode == 0) m_axis_tready = 1'b1;
                else if (mode == 2 && ($time - t0) < 110) m_axis_tready = 1'b0;
                else m_axis_tready = 1'($urandom_range(0, 1));
                if (inject) begin
                    pkt_len = LW'($urandom); pkt_count = 16'($urandom); gap = 8'($urandom);
                    seed = 8'($urandom); cfg_id = IDW'($urandom); cfg_dest = DSW'($urandom);
                    start = ($urandom_range(0, 3) == 0);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", 64'd1, 64'd0);
                    end else begin
                        eb = exp_q.pop_front();
                        check_eq("tdata", 64'(m_axis_tdata), 64'(eb.data));
                        check_eq("tkeep", 64'(m_axis_tkeep), 64'(eb.keep));
                        check_eq("tstrb", 64'(m_axis_tstrb), 64'(eb.keep));
                        check_eq("tlast", 64'(m_axis_tlast), 64'(eb.last));
                        check_eq("tuser", 64'(m_axis_tuser), 64'(eb.user));
                        check_eq("tid", 64'(m_axis_tid), 64'(eid));
                        check_eq("tdest", 64'(m_axis_tdest), 64'(edst));
                        if (eb.last && exp_q.size() == 0) expect_done = 1'b1;
                        else if (eb.last) begin
                            gap_mode = 1'b1;
                            idle = 0;
                        end
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_pl    = payload();
                step();
                cycles++;
            end
        end
        start = 1'b0;
        if (!finished) check_eq("run_timeout", 64'd0, 64'd1);
        check_eq("beats_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_test();
        run_check_reset:
        begin
            pkt_len = 16'd20; pkt_count = 16'd1; gap = 8'd0; seed = 8'h40;
            cfg_id = '1; cfg_dest = '1; m_axis_tready = 1'b1;
            start = 1'b1;
            step();
            start = 1'b0;
            step();
            step();
            check_eq("rst_beat2_valid", 64'(m_axis_tvalid), 64'd1);
            check_eq("rst_beat2_data", 64'(m_axis_tdata), 64'h4B4A4948);
            #2 areset = 1'b1;
            #1;
            check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
            check_eq("rst_busy", 64'(busy), 64'd0);
            check_eq("rst_done", 64'(done), 64'd0);
            check_eq("rst_payload", payload(), 64'd0);
            step();
            areset = 1'b0;
            for (int k = 0; k < 4; k++) begin
                step();
                check_eq("post_rst_idle", 64'({m_axis_tvalid, busy, done}), 64'd0);
            end
        end
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; pkt_len = '0; pkt_count = '0; gap = '0;
        seed = '0; cfg_id = '0; cfg_dest = '0; m_axis_tready = 1'b0;
        step();
        check_eq("reset_outputs", payload(), 64'd0);
        check_eq("reset_status", 64'({m_axis_tvalid, busy, done}), 64'd0);
        areset = 1'b0;
        step();
        run_test(4, 1, 0, 8'h10, 0, 1'b0, 1'b1, 32'h13121110);
        run_test(10, 2, 3, 8'hFE, 0, 1'b0, 1'b1, 32'h0100FFFE);
        run_test(13, 3, 2, 8'h33, 2, 1'b0, 1'b0, '0);
        run_test(8, 3, 0, 8'hA0, 0, 1'b0, 1'b0, '0);
        run_test(0, 2, 1, 8'h7F, 1, 1'b0, 1'b0, '0);
        run_test(5, 0, 0, 8'h00, 0, 1'b0, 1'b0, '0);
        run_test(9, 2, 1, 8'h55, 1, 1'b1, 1'b0, '0);
        reset_test();
        run_test(6, 1, 0, 8'hC8, 0, 1'b0, 1'b0, '0);
        for (int r = 0; r < 14; r++) begin
            run_test($urandom_range(0, 40), $urandom_range(0, 4), $urandom_range(0, 4),
                     8'($urandom), $urandom_range(1, 2), 1'($urandom_range(0, 1)), 1'b0, '0);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

Synthesizable, parametrised AXI-Stream packet source for the AXI-Stream bench and for on-chip loopback self-test. On a `start` pulse it emits `pkt_count` packets of `pkt_len` bytes each, with a deterministic incrementing byte pattern, partial-last-beat `tkeep`, SOF marking on `tuser`, and a programmable inter-packet gap. It fully honours `tready` backpressure. It replaces the fixed-width behavioural master with a width-generic, cycle-accurate RTL master that sits directly on an `axis_if` master port.

## Interface
- `DATA_W`, 32, tdata width in bits; must be a multiple of 8, range 8..512.
- `ID_W`, 1, tid width.
- `DEST_W`, 1, tdest width.
- `LEN_W`, 16, width of `pkt_len`.
- `aclk` in 1: the only clock.
- `areset` in 1: **asynchronous, active-high** reset.
- `start` in 1: single-cycle command pulse. Sampled only in IDLE.
- `pkt_len` in LEN_W: packet length in bytes. A value of 0 is treated as 1.
- `pkt_count` in 16: number of packets to send. A value of 0 means no packets.
- `gap` in 8: idle cycles between packets.
- `seed` in 8: first byte of the first packet.
- `cfg_id` in ID_W: tid value, constant for the whole run.
- `cfg_dest` in DEST_W: tdest value, constant for the whole run.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle `done` is asserted.
- `done` out 1: one-cycle pulse at the end of a run.
- `m_axis_tvalid` out 1: AXI-Stream valid.
- `m_axis_tready` in 1: AXI-Stream ready.
- `m_axis_tdata` out DATA_W: AXI-Stream data.
- `m_axis_tstrb` out DATA_W/8: AXI-Stream strobe.
- `m_axis_tkeep` out DATA_W/8: AXI-Stream keep.
- `m_axis_tlast` out 1: AXI-Stream last.
- `m_axis_tid` out ID_W: AXI-Stream ID.
- `m_axis_tdest` out DEST_W: AXI-Stream destination.
- `m_axis_tuser` out 1: start-of-frame flag.

## Operation
- **States:** IDLE, SEND, GAP, DONE.
- **IDLE:**
  - On `start`, latch all `cfg_*`, `pkt_len`, `pkt_count`, `gap` and `seed`.
  - If `pkt_count` is 0, go to DONE. Otherwise go to SEND.
- **SEND:** presents beats. A beat is accepted when `tvalid && tready`.
- **Beat count:** B = DATA_W/8. Beats per packet = ceil(len/B).
- **Data pattern:**
  - Byte lane j of beat i in packet p carries `(seed + p + i*B + j) mod 256`.
  - p counts from 0; all arithmetic is 8-bit wrap.
- **Keep/strobe:**
  - `tkeep` is all-ones on every non-last beat.
  - On the last beat, the low `len mod B` bits are set; if `len mod B` is 0, all bits are set.
  - Lanes with `tkeep` low drive 0 on tdata.
  - `tstrb` equals `tkeep`.
- **tlast:** high on the last beat only.
- **tuser:** high on the first beat of each packet only. A single-beat packet has `tuser` and `tlast` both high.
- **After a tlast handshake:**
  - If packets remain and `gap` > 0, go to GAP and count `gap` cycles with `tvalid` low, then return to SEND.
  - If packets remain and `gap` is 0, the next packet's first beat is presented in the cycle immediately after (back-to-back).
  - If it was the last packet, go to DONE.
- **DONE:** assert `done` for one cycle, then return to IDLE.
- **`start` while busy:** ignored. Configuration inputs may change freely once latched.
- **AXIS rules:**
  - Once `tvalid` is asserted, it and all payload signals stay stable until the handshake.
  - `tvalid` never depends combinationally on `tready`.

## Timing
- All outputs are registered.
- **Reset values:** all outputs are 0 and the state is IDLE. Reset asserted mid-packet drops `tvalid` immediately (asynchronous). No resumption after release.
- **Start latency:** `start` high at edge N (in IDLE) gives `busy` and `tvalid` with beat 0 at edge N+1.
- **Throughput:** with `tready` held high, one beat per cycle, with no bubble between beats of a packet.
- **Backpressure:** with `tready` low, the beat is held indefinitely. The next beat appears the cycle after the handshake.
- **Gap:** exactly `gap` cycles with `tvalid` low between the tlast handshake cycle and the next first beat.
- **End of run:** `done` is high in the cycle after the final tlast handshake, and `busy` drops in the same cycle.
- **Zero packets:** with `pkt_count` = 0, `done` is at N+1 with no beats, and `busy` never rises.
- **Counters:**
  - The beat counter is sized for ceil(2^LEN_W/B).
  - The packet counter is 16 bits.
  - Neither counter wraps within a run.

## Test plan
- **Single-beat packet:** DATA_W=32, `pkt_len`=4, `pkt_count`=1, `seed`=0x10, `tready`=1 → one beat with tdata 0x13121110, tkeep 0xF, tlast=1, tuser=1. `done` at start+2.
- **Partial last beat:** `pkt_len`=10, `pkt_count`=2, `gap`=3, `seed`=0xFE, `tready`=1 →
  - Packet 0 beats: 0x0100FFFE, 0x05040302, 0x00000706 (keep 0x3).
  - Exactly 3 idle cycles follow.
  - Packet 1 starts with byte 0xFF.
- **Backpressure:** `tready` held low for 110 ns after start (as in the existing bench), then toggled randomly → each beat's payload is held stable while stalled. Received byte stream equals the reference pattern, with no drops or duplicates.
- **Back-to-back:** `gap`=0, `pkt_count`=3, `pkt_len`=8, `tready`=1 → 6 consecutive valid cycles. tlast on cycles 2, 4, 6; tuser on cycles 1, 3, 5.
- **Zero count / ignored start:** `pkt_count`=0 → `done` 1 cycle later with no tvalid. A second `start` while busy → no effect on count or data.
- **Mid-packet reset:** assert `areset` during beat 2 of a 5-beat packet → all outputs are 0 asynchronously. After release the block stays IDLE until the next `start`.
